// File: rtl/sel_serial_tx.sv
// Serial data/select transmitter: accepts a parallel word on a valid/ready
// handshake and shifts it out one bit per clock with SEL low, then idles for GAP cycles.
module sel_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             OUT1,
    output logic             SEL,
    output logic             BUSY,
    output logic [1:0]       state_dbg
);

    // Handshake: a word is taken at a rising edge where DVALID and DREADY are
    // both high; the source holds DIN/DVALID stable until that edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_INIT = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  sreg;
    logic [CW-1:0]     bit_cnt;
    logic [3:0]        gap_cnt;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // OUT1/SEL are registered: the head bit is launched on the handshake edge,
    // so sreg always holds the not-yet-sent remainder of the word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            OUT1    <= 1'b0;
            SEL     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (DVALID) begin
                        sreg    <= advance(DIN);
                        bit_cnt <= BIT_INIT;
                        OUT1    <= head(DIN);
                        SEL     <= 1'b0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == '0) begin
                        OUT1 <= 1'b0;
                        SEL  <= 1'b1;
                        if (GAP > 0) begin
                            gap_cnt <= GAP_INIT;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        OUT1    <= head(sreg);
                        sreg    <= advance(sreg);
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    OUT1  <= 1'b0;
                    SEL   <= 1'b1;
                end
            endcase
        end
    end

    assign DREADY    = (state == S_IDLE) && !RST;
    assign BUSY      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sel_serial_tx.sv
// Directed bench for sel_serial_tx: three instances cover MSB-first/GAP=1,
// LSB-first/GAP=0 back-to-back, and WIDTH=1/GAP=3.
module tb_sel_serial_tx;

    logic       CLK = 1'b0;
    logic       RST;

    logic [7:0] din_m, din_l;
    logic [0:0] din_w;
    logic       dv_m, dv_l, dv_w;
    logic       rdy_m, out_m, sel_m, busy_m;
    logic       rdy_l, out_l, sel_l, busy_l;
    logic       rdy_w, out_w, sel_w, busy_w;
    logic [1:0] st_m, st_l, st_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sel_serial_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) u_m (
        .CLK(CLK), .RST(RST), .DIN(din_m), .DVALID(dv_m), .DREADY(rdy_m),
        .OUT1(out_m), .SEL(sel_m), .BUSY(busy_m), .state_dbg(st_m));

    sel_serial_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_l (
        .CLK(CLK), .RST(RST), .DIN(din_l), .DVALID(dv_l), .DREADY(rdy_l),
        .OUT1(out_l), .SEL(sel_l), .BUSY(busy_l), .state_dbg(st_l));

    sel_serial_tx #(.WIDTH(1), .GAP(3), .MSB_FIRST(1'b1)) u_w (
        .CLK(CLK), .RST(RST), .DIN(din_w), .DVALID(dv_w), .DREADY(rdy_w),
        .OUT1(out_w), .SEL(sel_w), .BUSY(busy_w), .state_dbg(st_w));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks {OUT1, SEL, DREADY, BUSY} of one instance as a 4-bit vector.
    task automatic chk4(input string tag, input logic o, input logic s, input logic r,
                        input logic b, input logic [3:0] exp);
        chk(tag, {28'd0, o, s, r, b}, {28'd0, exp});
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Hand-written OUT1 sequences in transmit order.
    logic exp_a5    [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic exp_lsb01 [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic exp_lsb80 [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        RST = 1'b1;
        din_m = 8'h00; din_l = 8'h00; din_w = 1'b0;
        dv_m = 1'b0; dv_l = 1'b0; dv_w = 1'b0;

        // ---- reset values: RST for 3 edges
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            step();
            chk4($sformatf("rst_m c%0d", i), out_m, sel_m, rdy_m, busy_m, 4'b0100);
            chk4($sformatf("rst_l c%0d", i), out_l, sel_l, rdy_l, busy_l, 4'b0100);
            chk4($sformatf("rst_w c%0d", i), out_w, sel_w, rdy_w, busy_w, 4'b0100);
        end
        RST = 1'b0;
        #1;
        chk4("post_rst_m", out_m, sel_m, rdy_m, busy_m, 4'b0110);
        chk4("post_rst_l", out_l, sel_l, rdy_l, busy_l, 4'b0110);
        chk4("post_rst_w", out_w, sel_w, rdy_w, busy_w, 4'b0110);
        step();
        chk4("idle_m", out_m, sel_m, rdy_m, busy_m, 4'b0110);

        // ---- MSB-first A5, DIN switched to FF mid-frame with DVALID held
        din_m = 8'hA5; dv_m = 1'b1;
        step();                           // cycle N+1
        din_m = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk4($sformatf("a5 bit%0d", i), out_m, sel_m, rdy_m, busy_m,
                 {exp_a5[i], 1'b0, 1'b0, 1'b1});
            step();
        end
        chk4("a5 gap", out_m, sel_m, rdy_m, busy_m, 4'b0101);    // N+9
        step();
        chk4("a5 ready", out_m, sel_m, rdy_m, busy_m, 4'b0110);  // N+10, FF accepted here
        step();
        for (int i = 0; i < 3; i++) begin
            chk4($sformatf("ff bit%0d", i), out_m, sel_m, rdy_m, busy_m, 4'b1001);
            if (i < 2) step();
        end

        // ---- reset mid-frame, with a handshake attempt during RST
        RST = 1'b1; dv_m = 1'b1; din_m = 8'hFF;
        #1;
        chk("rst_dready_low", {31'd0, rdy_m}, 32'd0);
        step();
        chk4("abort_m", out_m, sel_m, rdy_m, busy_m, 4'b0100);
        RST = 1'b0; dv_m = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rdy_m}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk4($sformatf("abort_idle%0d", i), out_m, sel_m, rdy_m, busy_m, 4'b0110);
        end

        // ---- LSB-first back-to-back, GAP=0
        din_l = 8'h01; dv_l = 1'b1;
        step();                           // N+1
        din_l = 8'h80;
        for (int i = 0; i < 8; i++) begin
            chk4($sformatf("l01 bit%0d", i), out_l, sel_l, rdy_l, busy_l,
                 {exp_lsb01[i], 1'b0, 1'b0, 1'b1});
            step();
        end
        chk4("l01 idle", out_l, sel_l, rdy_l, busy_l, 4'b0110);  // N+9, second accept
        step();                           // N+10
        dv_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk4($sformatf("l80 bit%0d", i), out_l, sel_l, rdy_l, busy_l,
                 {exp_lsb80[i], 1'b0, 1'b0, 1'b1});
            step();
        end
        chk4("l80 idle", out_l, sel_l, rdy_l, busy_l, 4'b0110);
        step();
        chk4("l80 idle2", out_l, sel_l, rdy_l, busy_l, 4'b0110);

        // ---- WIDTH=1, GAP=3
        din_w = 1'b1; dv_w = 1'b1;
        step();                           // N+1
        dv_w = 1'b0;
        chk4("w1 bit", out_w, sel_w, rdy_w, busy_w, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            step();
            chk4($sformatf("w1 gap%0d", i), out_w, sel_w, rdy_w, busy_w, 4'b0101);
        end
        step();                           // N+5
        chk4("w1 ready", out_w, sel_w, rdy_w, busy_w, 4'b0110);
        step();
        chk4("w1 idle", out_w, sel_w, rdy_w, busy_w, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
